// File: rtl/altsyncram_arb_pkg.sv
// Shared types and helpers for the two-client altsyncram port-A arbiter.
package altsyncram_arb_pkg;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

  // Cycles from request handshake to read response: one cycle to register
  // the command onto the RAM port, one for the RAM's registered address,
  // plus one more when the RAM output register is enabled.
  function automatic int rd_lat(input int outdata_reg);
    return 2 + outdata_reg;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic with its priority pointer.
module rr_arb2
  import altsyncram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       sclr,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Id of the requester granted most recently; reset to 1 so requester 0
  // wins the first contention.
  req_id_t last;

  // Combinational one-hot grant; nothing is granted while in reset.
  always_comb begin
    grant = 2'b00;
    if (!sclr) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Priority pointer moves only when somebody is actually granted.
  always_ff @(posedge clk) begin
    if (sclr) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/altsyncram_arbiter.sv
// Round-robin arbiter sharing port A of a single-port altsyncram between two
// clients. Handshake: a request transfers in a cycle where req_valid_i and
// req_ready_i are both high; a requester keeps every request field stable
// while valid is high and ready is low. Read responses are one-cycle
// rsp_valid_i pulses with no backpressure, a fixed rd_lat cycles after the
// handshake, always in acceptance order.
module altsyncram_arbiter
  import altsyncram_arb_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int WIDTHAD       = 10,
  parameter int WIDTH_BYTEENA = 4,
  parameter int OUTDATA_REG   = 0
) (
  input  logic                     clock0,
  input  logic                     sclr,
  input  logic                     req_valid_0,
  output logic                     req_ready_0,
  input  logic                     req_wr_0,
  input  logic [WIDTHAD-1:0]       req_addr_0,
  input  logic [WIDTH-1:0]         req_data_0,
  input  logic [WIDTH_BYTEENA-1:0] req_byteena_0,
  output logic                     rsp_valid_0,
  output logic [WIDTH-1:0]         rsp_data_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_1,
  input  logic                     req_wr_1,
  input  logic [WIDTHAD-1:0]       req_addr_1,
  input  logic [WIDTH-1:0]         req_data_1,
  input  logic [WIDTH_BYTEENA-1:0] req_byteena_1,
  output logic                     rsp_valid_1,
  output logic [WIDTH-1:0]         rsp_data_1,
  output logic                     ram_wren,
  output logic                     ram_rden,
  output logic [WIDTHAD-1:0]       ram_address,
  output logic [WIDTH-1:0]         ram_data,
  output logic [WIDTH_BYTEENA-1:0] ram_byteena,
  input  logic [WIDTH-1:0]         ram_q
);

  localparam int RD_LAT = rd_lat(OUTDATA_REG);

  // RAM port command; field widths follow this instance's parameters, so the
  // struct lives here rather than in the package.
  typedef struct packed {
    logic                     wren;
    logic                     rden;
    logic [WIDTHAD-1:0]       address;
    logic [WIDTH-1:0]         data;
    logic [WIDTH_BYTEENA-1:0] byteena;
  } ram_cmd_t;

  logic [1:0]        grant;
  logic              rd_accept;
  ram_cmd_t          cmd_next;
  ram_cmd_t          cmd_q;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;

  rr_arb2 u_arb (
    .clk   (clock0),
    .sclr  (sclr),
    .valid ({req_valid_1, req_valid_0}),
    .grant (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign rd_accept   = (grant[0] & ~req_wr_0) | (grant[1] & ~req_wr_1);

  // Next RAM command: the granted request, or an idle cycle that keeps
  // address/data/byteena at their previous values.
  always_comb begin
    cmd_next      = cmd_q;
    cmd_next.wren = 1'b0;
    cmd_next.rden = 1'b0;
    if (grant[1]) begin
      cmd_next.wren    = req_wr_1;
      cmd_next.rden    = ~req_wr_1;
      cmd_next.address = req_addr_1;
      cmd_next.data    = req_data_1;
      cmd_next.byteena = req_byteena_1;
    end else if (grant[0]) begin
      cmd_next.wren    = req_wr_0;
      cmd_next.rden    = ~req_wr_0;
      cmd_next.address = req_addr_0;
      cmd_next.data    = req_data_0;
      cmd_next.byteena = req_byteena_0;
    end
  end

  // RAM command register.
  always_ff @(posedge clock0) begin
    if (sclr) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_next;
    end
  end

  // Read tag pipeline: shifts one stage per cycle, so the oldest stage lines
  // up exactly with the RAM's q for that read. Reset drops in-flight reads.
  always_ff @(posedge clock0) begin
    if (sclr) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[RD_LAT-2:0], rd_accept};
      tag_id <= {tag_id[RD_LAT-2:0], grant[1]};
    end
  end

  assign ram_wren    = cmd_q.wren;
  assign ram_rden    = cmd_q.rden;
  assign ram_address = cmd_q.address;
  assign ram_data    = cmd_q.data;
  assign ram_byteena = cmd_q.byteena;

  assign rsp_valid_0 = ~sclr & tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1];
  assign rsp_valid_1 = ~sclr & tag_v[RD_LAT-1] & tag_id[RD_LAT-1];
  assign rsp_data_0  = ram_q;
  assign rsp_data_1  = ram_q;

endmodule

// File: tb/tb_altsyncram_arbiter.sv
// Bench for altsyncram_arbiter: one instance with an unregistered RAM output
// and one with the output register enabled, each beside a behavioural
// single-port RAM with byte enables.
module tb_altsyncram_arbiter;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int EW = 16 + 1 + W; // {due cycle, id, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sclr = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // ---------------- DUT, OUTDATA_REG = 0 ----------------
  logic          v0 = 0, v1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [W-1:0]  d0 = '0, d1 = '0;
  logic [BW-1:0] be0 = '0, be1 = '0;
  logic          rdy0, rdy1, rv0, rv1;
  logic [W-1:0]  rd0, rd1;
  logic          ram_wren, ram_rden;
  logic [AW-1:0] ram_address;
  logic [W-1:0]  ram_data, ram_q;
  logic [BW-1:0] ram_byteena;

  altsyncram_arbiter #(.WIDTH(W), .WIDTHAD(AW), .WIDTH_BYTEENA(BW), .OUTDATA_REG(0)) dut (
    .clock0(clk), .sclr(sclr),
    .req_valid_0(v0), .req_ready_0(rdy0), .req_wr_0(wr0), .req_addr_0(a0),
    .req_data_0(d0), .req_byteena_0(be0), .rsp_valid_0(rv0), .rsp_data_0(rd0),
    .req_valid_1(v1), .req_ready_1(rdy1), .req_wr_1(wr1), .req_addr_1(a1),
    .req_data_1(d1), .req_byteena_1(be1), .rsp_valid_1(rv1), .rsp_data_1(rd1),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_address(ram_address),
    .ram_data(ram_data), .ram_byteena(ram_byteena), .ram_q(ram_q)
  );

  // Single-port RAM model, unregistered output.
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] q_a = '0;
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < BW; b++)
        if (ram_byteena[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
    if (ram_rden) q_a <= mem[ram_address];
  end
  assign ram_q = q_a;

  // ---------------- DUT, OUTDATA_REG = 1 ----------------
  logic          r_v0 = 0, r_v1 = 0, r_wr0 = 0;
  logic [AW-1:0] r_a0 = '0;
  logic [W-1:0]  r_d0 = '0;
  logic          r_rdy0, r_rdy1, r_rv0, r_rv1;
  logic [W-1:0]  r_rd0, r_rd1;
  logic          r_wren, r_rden;
  logic [AW-1:0] r_address;
  logic [W-1:0]  r_data, r_q;
  logic [BW-1:0] r_byteena;
  logic [AW-1:0] r_zero_a = '0;
  logic [W-1:0]  r_zero_d = '0;
  logic [BW-1:0] r_be = 4'hF;

  altsyncram_arbiter #(.WIDTH(W), .WIDTHAD(AW), .WIDTH_BYTEENA(BW), .OUTDATA_REG(1)) dut_r (
    .clock0(clk), .sclr(sclr),
    .req_valid_0(r_v0), .req_ready_0(r_rdy0), .req_wr_0(r_wr0), .req_addr_0(r_a0),
    .req_data_0(r_d0), .req_byteena_0(r_be), .rsp_valid_0(r_rv0), .rsp_data_0(r_rd0),
    .req_valid_1(r_v1), .req_ready_1(r_rdy1), .req_wr_1(1'b0), .req_addr_1(r_zero_a),
    .req_data_1(r_zero_d), .req_byteena_1(r_be), .rsp_valid_1(r_rv1), .rsp_data_1(r_rd1),
    .ram_wren(r_wren), .ram_rden(r_rden), .ram_address(r_address),
    .ram_data(r_data), .ram_byteena(r_byteena), .ram_q(r_q)
  );

  // Single-port RAM model, registered output (one extra cycle).
  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_q_int = '0;
  logic [W-1:0] r_q_out = '0;
  always @(posedge clk) begin
    if (r_wren)
      for (int b = 0; b < BW; b++)
        if (r_byteena[b]) r_mem[r_address][8*b +: 8] <= r_data[8*b +: 8];
    if (r_rden) r_q_int <= r_mem[r_address];
    r_q_out <= r_q_int;
  end
  assign r_q = r_q_out;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] r_exp_q[$];
  logic [EW-1:0] e, r_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the unregistered-output instance.
  always begin
    @(negedge clk); #2;
    if (rv0 || rv1) begin
      chk("rsp_onehot", {63'b0, rv0 & rv1}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {62'b0, rv1, rv0}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), {48'b0, e[EW-1:W+1]});
        chk("rsp_id", {63'b0, rv1}, {63'b0, e[W]});
        chk("rsp_data", {32'b0, rv1 ? rd1 : rd0}, {32'b0, e[W-1:0]});
      end
    end
  end

  // Monitor for the registered-output instance.
  always begin
    @(negedge clk); #2;
    if (r_rv0 || r_rv1) begin
      if (r_exp_q.size() == 0) begin
        chk("r_rsp_unexpected", {62'b0, r_rv1, r_rv0}, 64'd0);
      end else begin
        r_e = r_exp_q.pop_front();
        chk("r_rsp_cycle", 64'(cyc), {48'b0, r_e[EW-1:W+1]});
        chk("r_rsp_id", {63'b0, r_rv1}, {63'b0, r_e[W]});
        chk("r_rsp_data", {32'b0, r_rv1 ? r_rd1 : r_rd0}, {32'b0, r_e[W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v0 = 0; v1 = 0;
    end
  endtask

  // Single-requester request; returns at #1 after the negedge of the
  // handshake cycle with valid still high, so consecutive calls issue
  // back-to-back requests.
  task automatic drive_req(input int id, input logic wr, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic [BW-1:0] be,
                           input logic [W-1:0] exp_d, input bit expect_rsp);
    int waited;
    logic got;
    waited = 0;
    @(negedge clk);
    v0 = 0; v1 = 0;
    if (id == 0) begin v0 = 1; wr0 = wr; a0 = a; d0 = d; be0 = be; end
    else         begin v1 = 1; wr1 = wr; a1 = a; d1 = d; be1 = be; end
    #1;
    got = (id == 0) ? rdy0 : rdy1;
    while (!got && waited < 8) begin
      @(negedge clk); #1;
      got = (id == 0) ? rdy0 : rdy1;
      waited++;
    end
    chk("handshake", {63'b0, got}, 64'd1);
    if (got && !wr && expect_rsp)
      exp_q.push_back({16'(cyc + 2), id[0], exp_d});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, {60'b0, rdy0, rdy1, r_rdy0, r_rdy1}, 64'd0);
    chk({tag, "_rsp_valid"}, {60'b0, rv0, rv1, r_rv0, r_rv1}, 64'd0);
    chk({tag, "_wren_rden"}, {60'b0, ram_wren, ram_rden, r_wren, r_rden}, 64'd0);
    chk({tag, "_address"}, {44'b0, ram_address, r_address}, 64'd0);
    chk({tag, "_data"}, {ram_data, r_data}, 64'd0);
    chk({tag, "_byteena"}, {56'b0, ram_byteena, r_byteena}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, n1;

    // Reset with requests pending: nothing may be granted or emitted.
    sclr = 1; v0 = 1; v1 = 1; r_v0 = 1;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    v0 = 0; v1 = 0; r_v0 = 0;
    sclr = 0;

    // Requester 0 writes DEADBEEF to address 5, then reads it back.
    drive_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, '0, 1'b0);
    idle(1); #1;
    chk("wr_wren", {63'b0, ram_wren}, 64'd1);
    chk("wr_rden", {63'b0, ram_rden}, 64'd0);
    chk("wr_addr", {54'b0, ram_address}, 64'd5);
    chk("wr_data", {32'b0, ram_data}, 64'hDEADBEEF);
    drive_req(0, 1'b0, 10'd5, '0, 4'hF, 32'hDEADBEEF, 1'b1);
    idle(1); #1;
    chk("rd_rden", {62'b0, ram_wren, ram_rden}, 64'd1);
    idle(4);

    // Preload addresses 16..23 with A000_0000 | addr.
    for (int i = 16; i < 24; i++)
      drive_req(0, 1'b1, 10'(i), 32'hA000_0000 | i, 4'hF, '0, 1'b0);
    idle(2);

    // Fresh reset, then both requesters read continuously for 8 cycles.
    @(negedge clk); sclr = 1;
    @(negedge clk); sclr = 0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v0 = 1; wr0 = 0; a0 = 10'(16 + n0);
      v1 = 1; wr1 = 0; a1 = 10'(20 + n1);
      #1;
      chk("alt_grant", {62'b0, rdy1, rdy0}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (rdy0) begin
        exp_q.push_back({16'(cyc + 2), 1'b0, 32'hA000_0000 | (16 + n0)});
        n0++;
      end
      if (rdy1) begin
        exp_q.push_back({16'(cyc + 2), 1'b1, 32'hA000_0000 | (20 + n1)});
        n1++;
      end
    end
    idle(4);

    // Byte-masked write by requester 1 over 0x11223344, read next cycle.
    drive_req(0, 1'b1, 10'd3, 32'h11223344, 4'hF, '0, 1'b0);
    drive_req(1, 1'b1, 10'd3, 32'h000000AA, 4'b0001, '0, 1'b0);
    drive_req(0, 1'b0, 10'd3, '0, 4'hF, 32'h112233AA, 1'b1);
    idle(4);

    // Contention after a requester-0 grant: requester 1 wins, requester 0
    // holds its request and is accepted the following cycle.
    @(negedge clk);
    v0 = 1; wr0 = 0; a0 = 10'd5;
    v1 = 1; wr1 = 0; a1 = 10'd16;
    #1;
    chk("hold_grant1", {62'b0, rdy1, rdy0}, 64'd2);
    if (rdy1) exp_q.push_back({16'(cyc + 2), 1'b1, 32'hA000_0010});
    @(negedge clk);
    v1 = 0;
    #1;
    chk("hold_grant0", {62'b0, rdy1, rdy0}, 64'd1);
    chk("hold_addr_stable", {54'b0, a0}, 64'd5);
    if (rdy0) exp_q.push_back({16'(cyc + 2), 1'b0, 32'hDEADBEEF});
    idle(4);

    // Two reads accepted, then reset: their responses must vanish.
    drive_req(0, 1'b0, 10'd5, '0, 4'hF, '0, 1'b0);
    drive_req(0, 1'b0, 10'd16, '0, 4'hF, '0, 1'b0);
    @(negedge clk);
    sclr = 1; v0 = 1; v1 = 1;
    #1;
    chk("rst_ready_gated", {62'b0, rdy1, rdy0}, 64'd0);
    @(negedge clk); #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    sclr = 0; v0 = 0; v1 = 0;
    idle(6);

    // Registered-output instance: 4 writes then 4 reads, one per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r_v0 = 1; r_wr0 = (i < 4);
      r_a0 = 10'(40 + (i % 4));
      r_d0 = 32'hC0DE_0000 | (i % 4);
      #1;
      chk("r_ready", {62'b0, r_rdy1, r_rdy0}, 64'd1);
      if (r_rdy0 && i >= 4)
        r_exp_q.push_back({16'(cyc + 3), 1'b0, 32'hC0DE_0000 | (i % 4)});
    end
    @(negedge clk); r_v0 = 0;
    idle(6);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("r_exp_q_empty", 64'(r_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
